// File: rtl/powerup_controller_pkg.sv
// Shared definitions for the time-turner pickup: state encodings, default
// geometry/timing constants and the Moore output decode used by HUD and compositor.
package powerup_controller_pkg;

    typedef enum logic [1:0] {
        ST_SPAWNED  = 2'd0,
        ST_HELD     = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_COOLDOWN = 2'd3
    } pu_state_t;

    localparam int DEF_ITEM_ROW        = 340;
    localparam int DEF_ITEM_COL        = 120;
    localparam int DEF_ITEM_SIZE       = 100;
    localparam int DEF_ACTIVE_CYCLES   = 250000000;
    localparam int DEF_COOLDOWN_CYCLES = 100000000;
    localparam int DEF_CNT_W           = 28;

    typedef struct packed {
        logic item_visible;
        logic powerup_held;
        logic time_turner_powerup;
        logic cooldown;
    } pu_outputs_t;

    // Exactly one flag is high in every state.
    function automatic pu_outputs_t decode_outputs(pu_state_t st);
        pu_outputs_t o;
        o = '0;
        case (st)
            ST_SPAWNED:  o.item_visible        = 1'b1;
            ST_HELD:     o.powerup_held        = 1'b1;
            ST_ACTIVE:   o.time_turner_powerup = 1'b1;
            ST_COOLDOWN: o.cooldown            = 1'b1;
            default:     o.item_visible        = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/powerup_controller_if.sv
// Player/button inputs and status outputs of the time-turner pickup controller.
interface powerup_controller_if;
    // player_valid is a one-cycle strobe qualifying player_row/player_col;
    // there is no ready: the controller samples every strobe it is given.
    logic [8:0] player_row;
    logic [9:0] player_col;
    logic       player_valid;
    logic       use_btn;
    logic       time_turner_powerup;
    logic       item_visible;
    logic       powerup_held;
    logic       cooldown;
    logic [1:0] state;

    modport master (
        output player_row, player_col, player_valid, use_btn,
        input  time_turner_powerup, item_visible, powerup_held, cooldown, state
    );

    modport slave (
        input  player_row, player_col, player_valid, use_btn,
        output time_turner_powerup, item_visible, powerup_held, cooldown, state
    );
endinterface

// File: rtl/rise_edge_detect.sv
// Single-cycle pulse on each rising edge of an already-synchronized level.
module rise_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= in;
    end

    assign pulse = in & ~prev;
endmodule

// File: rtl/powerup_controller.sv
// Time-turner pickup lifecycle: spawned -> held -> active window -> cooldown -> respawn.
module powerup_controller
    import powerup_controller_pkg::*;
#(
    parameter int ITEM_ROW        = DEF_ITEM_ROW,
    parameter int ITEM_COL        = DEF_ITEM_COL,
    parameter int ITEM_SIZE       = DEF_ITEM_SIZE,
    parameter int ACTIVE_CYCLES   = DEF_ACTIVE_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input logic            clk,
    input logic            reset,
    powerup_controller_if.slave bus
);
    localparam logic [10:0] ROW_LO = 11'(ITEM_ROW);
    localparam logic [10:0] ROW_HI = 11'(ITEM_ROW + ITEM_SIZE);
    localparam logic [10:0] COL_LO = 11'(ITEM_COL);
    localparam logic [10:0] COL_HI = 11'(ITEM_COL + ITEM_SIZE);
    localparam logic [CNT_W-1:0] ACTIVE_LOAD   = CNT_W'(ACTIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    pu_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             use_edge;
    logic             hit;
    logic [10:0]      row_w, col_w;
    pu_outputs_t      outs;

    // The edge detector runs in every state, so a press made while walking
    // onto the item is consumed and cannot activate it afterwards.
    rise_edge_detect u_use_edge (
        .clk  (clk),
        .reset(reset),
        .in   (bus.use_btn),
        .pulse(use_edge)
    );

    assign row_w = {2'b00, bus.player_row};
    assign col_w = {1'b0, bus.player_col};
    assign hit   = bus.player_valid
                   && (row_w >= ROW_LO) && (row_w < ROW_HI)
                   && (col_w >= COL_LO) && (col_w < COL_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SPAWNED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SPAWNED: begin
                if (hit) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (use_edge) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = ACTIVE_LOAD;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = COOLDOWN_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = ST_SPAWNED;
            end
            default: begin
                state_d = ST_SPAWNED;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        outs = decode_outputs(state_q);
    end

    assign bus.item_visible        = outs.item_visible;
    assign bus.powerup_held        = outs.powerup_held;
    assign bus.time_turner_powerup = outs.time_turner_powerup;
    assign bus.cooldown            = outs.cooldown;
    assign bus.state               = state_q;
endmodule

// File: tb/tb_powerup_controller.sv
// Scenario bench for powerup_controller with short active/cooldown windows.
module tb_powerup_controller;
    import powerup_controller_pkg::*;

    // {state, item_visible, powerup_held, time_turner_powerup, cooldown}
    localparam logic [5:0] V_SPAWN = 6'b00_1000;
    localparam logic [5:0] V_HELD  = 6'b01_0100;
    localparam logic [5:0] V_ACT   = 6'b10_0010;
    localparam logic [5:0] V_COOL  = 6'b11_0001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    powerup_controller_if bus ();

    powerup_controller #(
        .ACTIVE_CYCLES  (8),
        .COOLDOWN_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [5:0] exp_q[$];
    logic [5:0] got, e;
    int errors = 0;
    int checks = 0;

    function automatic logic [5:0] outs();
        return {bus.state, bus.item_visible, bus.powerup_held,
                bus.time_turner_powerup, bus.cooldown};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.player_valid = 1'b0;
        bus.player_row   = '0;
        bus.player_col   = '0;
        bus.use_btn      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        tick();
        exp_q.push_back(V_SPAWN);
        tick();
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_held: got %b expected %b", got, e); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(V_SPAWN);
            tick();
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL reset_idle[%0d]: got %b expected %b", i, got, e); end
        end
    endtask

    task automatic test_collect(input string tag, input logic [8:0] row,
                                input logic [9:0] col, input logic valid,
                                input logic collects);
        do_reset();
        bus.player_row   = row;
        bus.player_col   = col;
        bus.player_valid = valid;
        exp_q.push_back(collects ? V_HELD : V_SPAWN);
        tick();
        bus.player_valid = 1'b0;
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL collect_%s: got %b expected %b", tag, got, e); end
        exp_q.push_back(collects ? V_HELD : V_SPAWN);
        tick();
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL collect_%s_stay: got %b expected %b", tag, got, e); end
    endtask

    task automatic collect_item(input string tag);
        bus.player_row   = 9'd340;
        bus.player_col   = 10'd120;
        bus.player_valid = 1'b1;
        exp_q.push_back(V_HELD);
        tick();
        bus.player_valid = 1'b0;
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL %s_pickup: got %b expected %b", tag, got, e); end
    endtask

    task automatic test_activate();
        do_reset();
        collect_item("activate");
        bus.use_btn = 1'b1;
        exp_q.push_back(V_ACT);
        tick();
        bus.use_btn = 1'b0;
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL activate_entry: got %b expected %b", got, e); end
        for (int i = 1; i < 8; i++) exp_q.push_back(V_ACT);
        for (int i = 0; i < 4; i++) exp_q.push_back(V_COOL);
        exp_q.push_back(V_SPAWN);
        for (int i = 0; i < 12; i++) begin
            tick();
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL activate_window[%0d]: got %b expected %b", i, got, e); end
        end
        // The respawned item can be collected straight away.
        collect_item("respawn");
    endtask

    task automatic test_held_button();
        do_reset();
        bus.use_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(V_SPAWN);
            tick();
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL held_btn_spawned[%0d]: got %b expected %b", i, got, e); end
        end
        collect_item("held_btn");
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(V_HELD);
            tick();
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL held_btn_no_trigger[%0d]: got %b expected %b", i, got, e); end
        end
        bus.use_btn = 1'b0;
        exp_q.push_back(V_HELD);
        tick();
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL held_btn_release: got %b expected %b", got, e); end
        bus.use_btn = 1'b1;
        exp_q.push_back(V_ACT);
        tick();
        bus.use_btn = 1'b0;
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL held_btn_fresh_press: got %b expected %b", got, e); end
    endtask

    task automatic test_active_ignore();
        do_reset();
        collect_item("ignore");
        bus.use_btn = 1'b1;
        exp_q.push_back(V_ACT);
        tick();
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL ignore_entry: got %b expected %b", got, e); end
        for (int i = 1; i < 8; i++) begin
            bus.use_btn      = 1'($urandom_range(0, 1));
            bus.player_row   = 9'($urandom_range(340, 439));
            bus.player_col   = 10'($urandom_range(120, 219));
            bus.player_valid = 1'b1;
            exp_q.push_back(V_ACT);
            tick();
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL ignore_active[%0d]: got %b expected %b", i, got, e); end
        end
        drive_idle();
        for (int i = 0; i < 4; i++) exp_q.push_back(V_COOL);
        exp_q.push_back(V_SPAWN);
        for (int i = 0; i < 5; i++) begin
            tick();
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL ignore_tail[%0d]: got %b expected %b", i, got, e); end
        end

        // Reset in the third active cycle drops the powerup on the next edge.
        do_reset();
        collect_item("mid_reset");
        bus.use_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(V_ACT);
            tick();
            bus.use_btn = 1'b0;
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL mid_reset_active[%0d]: got %b expected %b", i, got, e); end
        end
        reset = 1'b1;
        exp_q.push_back(V_SPAWN);
        tick();
        reset = 1'b0;
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_reset_drop: got %b expected %b", got, e); end
        exp_q.push_back(V_SPAWN);
        tick();
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_reset_after: got %b expected %b", got, e); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick();
        bus.use_btn = 1'b1;
        collect_item("simul");
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(V_HELD);
            tick();
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL simul_held[%0d]: got %b expected %b", i, got, e); end
        end
        bus.use_btn = 1'b0;
        exp_q.push_back(V_HELD);
        tick();
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL simul_release: got %b expected %b", got, e); end
        bus.use_btn = 1'b1;
        exp_q.push_back(V_ACT);
        tick();
        bus.use_btn = 1'b0;
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL simul_new_press: got %b expected %b", got, e); end
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_collect("top_left",      9'd340, 10'd120, 1'b1, 1'b1);
        test_collect("bottom_right",  9'd439, 10'd219, 1'b1, 1'b1);
        test_collect("row_past_edge", 9'd440, 10'd120, 1'b1, 1'b0);
        test_collect("col_past_edge", 9'd340, 10'd220, 1'b1, 1'b0);
        test_collect("row_before",    9'd339, 10'd150, 1'b1, 1'b0);
        test_collect("no_valid",      9'd380, 10'd150, 1'b0, 1'b0);
        test_activate();
        test_held_button();
        test_active_ignore();
        test_simultaneous();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
